// File: rtl/lbr_dump_controller_if.sv
// LBR read port and dump stream bundle shared by the dump controller and its neighbours.
// master = controller side, slave = LBR unit / trace consumer side.
interface lbr_dump_controller_if #(
    parameter int DATA_WIDTH = 64,
    parameter int LBR_SIZE   = 16
);
    localparam int IW = $clog2(LBR_SIZE);
    localparam int AW = IW + 2;

    logic                  lbr_rd_en;
    logic [AW-1:0]         lbr_rd_addr;
    logic [DATA_WIDTH-1:0] lbr_rd_data;
    logic                  pipe_busy;

    logic                  dump_valid;
    logic                  dump_ready;
    logic [DATA_WIDTH-1:0] dump_from;
    logic [DATA_WIDTH-1:0] dump_to;
    logic [IW-1:0]         dump_seq;
    logic                  dump_last;

    modport master (
        output lbr_rd_en, lbr_rd_addr, dump_valid, dump_from, dump_to, dump_seq, dump_last,
        input  lbr_rd_data, pipe_busy, dump_ready
    );

    modport slave (
        input  lbr_rd_en, lbr_rd_addr, dump_valid, dump_from, dump_to, dump_seq, dump_last,
        output lbr_rd_data, pipe_busy, dump_ready
    );
endinterface

// File: rtl/lbr_dump_controller.sv
// Drains the LBR file newest-to-oldest onto a valid/ready stream, freezing recording
// while active and yielding the shared read port to the pipeline whenever it is busy.
module lbr_dump_controller #(
    parameter int DATA_WIDTH = 64,
    parameter int LBR_SIZE   = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [$clog2(LBR_SIZE):0] dump_count,
    output logic                      freeze,
    output logic                      busy,
    output logic                      done,
    lbr_dump_controller_if.master     bus
);
    localparam int IW = $clog2(LBR_SIZE);
    localparam int AW = IW + 2;
    localparam logic [IW:0] FULL = (IW+1)'(LBR_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        RD_TOS,
        RD_FROM,
        RD_TO,
        OUT,
        DONE
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [IW:0]           n;
    logic [IW:0]           n_clamp;
    logic [IW-1:0]         k;
    logic [IW-1:0]         tos;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] from_q;
    logic [DATA_WIDTH-1:0] to_q;
    logic                  rd_ok;
    logic                  accept;
    logic                  last;

    assign rd_ok   = !bus.pipe_busy && !abort;
    assign accept  = (state == IDLE) && start && !abort;
    assign n_clamp = (dump_count == '0 || dump_count > FULL) ? FULL : dump_count;
    // IW-bit subtract wraps modulo LBR_SIZE
    assign idx     = tos - k;
    assign last    = ({1'b0, k} == n - (IW+1)'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)         state_nx = RD_TOS;
            RD_TOS:  if (!bus.pipe_busy) state_nx = RD_FROM;
            RD_FROM: if (!bus.pipe_busy) state_nx = RD_TO;
            RD_TO:   if (!bus.pipe_busy) state_nx = OUT;
            OUT:     if (bus.dump_ready) state_nx = last ? DONE : RD_FROM;
            DONE:                        state_nx = IDLE;
            default:                     state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            n      <= '0;
            k      <= '0;
            tos    <= '0;
            from_q <= '0;
            to_q   <= '0;
        end else begin
            if (accept) begin
                n <= n_clamp;
                k <= '0;
            end
            if (rd_ok) begin
                case (state)
                    RD_TOS:  tos    <= bus.lbr_rd_data[IW-1:0];
                    RD_FROM: from_q <= bus.lbr_rd_data;
                    RD_TO:   to_q   <= bus.lbr_rd_data;
                    default: ;
                endcase
            end
            if (state == OUT && bus.dump_ready && !abort && !last) begin
                k <= k + IW'(1);
            end
        end
    end

    always_comb begin
        bus.lbr_rd_addr = {1'b1, {(AW-1){1'b0}}};
        case (state)
            RD_FROM: bus.lbr_rd_addr = {2'b00, idx};
            RD_TO:   bus.lbr_rd_addr = {2'b01, idx};
            default: ;
        endcase
    end

    assign busy           = (state != IDLE);
    assign freeze         = busy;
    assign done           = (state == DONE);
    assign bus.lbr_rd_en  = (state inside {RD_TOS, RD_FROM, RD_TO});
    assign bus.dump_valid = (state == OUT);
    assign bus.dump_last  = (state == OUT) && last;
    assign bus.dump_from  = from_q;
    assign bus.dump_to    = to_q;
    assign bus.dump_seq   = k;
endmodule
